// File: rtl/uidbufw_arbiter_rr_pkg.sv
// Shared definitions for the round-robin uidbuf write arbiter.
package uidbufw_arbiter_rr_pkg;

    // Legacy-compatible state encoding held in a 2-bit state field.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    // Channel index width; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uidbufw_arbiter_rr_if.sv
// Flattened per-channel uidbuf write buses plus the single FDMA write port.
interface uidbufw_arbiter_rr_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 21,
    parameter int SIZE_WIDTH     = 16,
    parameter int CH_NUM         = 4
);
    logic [CH_NUM*AXI_ADDR_WIDTH-1:0] s_waddr;
    logic [CH_NUM-1:0]                s_wareq;
    logic [CH_NUM*SIZE_WIDTH-1:0]     s_wsize;
    logic [CH_NUM-1:0]                s_wbusy;
    logic [CH_NUM*AXI_DATA_WIDTH-1:0] s_wdata;
    logic [CH_NUM-1:0]                s_wvalid;
    logic [AXI_ADDR_WIDTH-1:0]        fdma_waddr;
    logic                             fdma_wareq;
    logic [SIZE_WIDTH-1:0]            fdma_wsize;
    logic                             fdma_wbusy;
    logic [AXI_DATA_WIDTH-1:0]        fdma_wdata;
    logic                             fdma_wvalid;

    // Arbiter view: it masters the FDMA port on behalf of the channels.
    modport master (
        input  s_waddr, s_wareq, s_wsize, s_wdata, fdma_wbusy, fdma_wvalid,
        output s_wbusy, s_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata
    );

    // Environment view: uidbuf channels and the FDMA engine together.
    modport slave (
        output s_waddr, s_wareq, s_wsize, s_wdata, fdma_wbusy, fdma_wvalid,
        input  s_wbusy, s_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata
    );
endinterface

// File: rtl/uidbufw_arbiter_rr_rr_pick.sv
// Combinational round-robin selector: first request at or after ptr, with wrap.
module uidbufw_arbiter_rr_rr_pick #(
    parameter int CH_NUM = 4,
    parameter int IDX_W  = 2
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt,
    output logic              any
);
    logic [2*CH_NUM-1:0] req_dbl;

    assign req_dbl = {req, req};

    // Scan the doubled vector from ptr so the wrap needs no modulo arithmetic.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < 2 * CH_NUM; i++) begin
            if (!any && (i >= 32'(ptr)) && (i < 32'(ptr) + CH_NUM) && req_dbl[i]) begin
                any = 1'b1;
                gnt = (i >= CH_NUM) ? IDX_W'(i - CH_NUM) : IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/uidbufw_arbiter_rr.sv
// N-channel round-robin write arbiter from uidbuf write engines onto one FDMA port.
module uidbufw_arbiter_rr
    import uidbufw_arbiter_rr_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 21,
    parameter int SIZE_WIDTH     = 16,
    parameter int CH_NUM         = 4,
    localparam int CH_IDX_W      = ch_idx_w(CH_NUM)
) (
    input  logic                   ui_clk,
    input  logic                   ui_rstn,
    uidbufw_arbiter_rr_if.master   bus,
    output logic [CH_IDX_W-1:0]    gnt_id,
    output logic                   arb_active
);
    logic [1:0]                state;
    logic [CH_IDX_W-1:0]       ptr;
    logic [CH_IDX_W-1:0]       gnt_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [SIZE_WIDTH-1:0]     size_q;
    logic                      wareq_q;
    logic [CH_NUM-1:0]         wbusy_q;

    logic [CH_IDX_W-1:0]       pick;
    logic                      pick_any;
    logic [AXI_ADDR_WIDTH-1:0] pick_addr;
    logic [SIZE_WIDTH-1:0]     pick_size;
    logic [CH_NUM-1:0]         wvalid;

    uidbufw_arbiter_rr_rr_pick #(
        .CH_NUM (CH_NUM),
        .IDX_W  (CH_IDX_W)
    ) u_pick (
        .req (bus.s_wareq),
        .ptr (ptr),
        .gnt (pick),
        .any (pick_any)
    );

    // Address and size of the channel the selector would grant now.
    always_comb begin
        pick_addr = bus.s_waddr[pick*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        pick_size = bus.s_wsize[pick*SIZE_WIDTH +: SIZE_WIDTH];
    end

    // Grant FSM with latched address/size; requests are only sampled in IDLE.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wareq_q <= 1'b0;
            wbusy_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_q   <= pick;
                        addr_q  <= pick_addr;
                        size_q  <= pick_size;
                        wareq_q <= 1'b1;
                        wbusy_q <= CH_NUM'(1) << pick;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.fdma_wbusy) begin
                        wareq_q <= 1'b0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!bus.fdma_wbusy) begin
                        wbusy_q <= '0;
                        ptr     <= (gnt_q == CH_IDX_W'(CH_NUM - 1)) ? '0 : gnt_q + 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    addr_q  <= '0;
                    size_q  <= '0;
                    wareq_q <= 1'b0;
                    wbusy_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb_active = (state == ST_REQ) || (state == ST_BUSY);

    // Route the FDMA data strobe back to the granted channel only.
    always_comb begin
        wvalid = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            if (arb_active && (gnt_q == CH_IDX_W'(k))) begin
                wvalid[k] = bus.fdma_wvalid;
            end
        end
    end

    assign bus.s_wvalid   = wvalid;
    assign bus.s_wbusy    = wbusy_q;
    assign bus.fdma_waddr = addr_q;
    assign bus.fdma_wsize = size_q;
    assign bus.fdma_wareq = wareq_q;
    assign bus.fdma_wdata = arb_active ? bus.s_wdata[gnt_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : '0;
    assign gnt_id         = gnt_q;
endmodule

// File: tb/tb_uidbufw_arbiter_rr.sv
// Self-checking bench for uidbufw_arbiter_rr: 4-channel/32-bit and 3-channel/64-bit builds.
module tb_uidbufw_arbiter_rr;
    localparam int DW = 32;
    localparam int AW = 21;
    localparam int SW = 16;
    localparam int N  = 4;

    logic ui_clk = 1'b0;
    logic ui_rstn = 1'b0;
    logic [1:0] gnt_id4;
    logic       arb_active4;
    logic [1:0] gnt_id3;
    logic       arb_active3;

    int errors = 0;
    int checks = 0;
    int mptr   = 0;   // reference model: next channel in round-robin order

    always #5 ui_clk = ~ui_clk;

    uidbufw_arbiter_rr_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CH_NUM(N)) bus4 ();
    uidbufw_arbiter_rr_if #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CH_NUM(3)) bus3 ();

    uidbufw_arbiter_rr #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CH_NUM(N)) dut4 (
        .ui_clk     (ui_clk),
        .ui_rstn    (ui_rstn),
        .bus        (bus4),
        .gnt_id     (gnt_id4),
        .arb_active (arb_active4)
    );

    uidbufw_arbiter_rr #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CH_NUM(3)) dut3 (
        .ui_clk     (ui_clk),
        .ui_rstn    (ui_rstn),
        .bus        (bus3),
        .gnt_id     (gnt_id3),
        .arb_active (arb_active3)
    );

    // One complete grant/request/busy/release cycle on the 4-channel DUT.
    // Entered and left at a falling clock edge.
    task automatic burst(input logic [3:0] req, input int busy_len, input bit hold_req,
                         input bit rand_inputs, input bit noise, output int granted);
        int exp;
        int k;
        logic [AW-1:0] exp_addr;
        logic [SW-1:0] exp_size;
        logic [DW-1:0] exp_data;
        logic [3:0]    exp_vld;
        if (rand_inputs) begin
            for (int c = 0; c < N; c++) begin
                bus4.s_waddr[c*AW +: AW] = AW'($urandom);
                bus4.s_wsize[c*SW +: SW] = SW'($urandom);
            end
        end
        bus4.s_wareq = req;
        exp = -1;
        for (int i = 0; i < N; i++) begin
            k = (mptr + i) % N;
            if (exp < 0 && req[k]) exp = k;
        end
        exp_addr = bus4.s_waddr[exp*AW +: AW];
        exp_size = bus4.s_wsize[exp*SW +: SW];
        @(negedge ui_clk);
        checks++;
        if (bus4.fdma_wareq !== 1'b1) begin errors++; $display("FAIL grant_wareq got=%b want=1", bus4.fdma_wareq); end
        checks++;
        if (gnt_id4 !== 2'(exp)) begin errors++; $display("FAIL grant_id got=%0d want=%0d", gnt_id4, exp); end
        checks++;
        if (bus4.s_wbusy !== 4'(1 << exp)) begin errors++; $display("FAIL grant_wbusy got=%b want=%b", bus4.s_wbusy, 4'(1 << exp)); end
        checks++;
        if (bus4.fdma_waddr !== exp_addr) begin errors++; $display("FAIL grant_addr got=%h want=%h", bus4.fdma_waddr, exp_addr); end
        checks++;
        if (bus4.fdma_wsize !== exp_size) begin errors++; $display("FAIL grant_size got=%h want=%h", bus4.fdma_wsize, exp_size); end
        checks++;
        if (arb_active4 !== 1'b1) begin errors++; $display("FAIL grant_active got=%b want=1", arb_active4); end
        if (!hold_req) bus4.s_wareq[exp] = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge ui_clk);
            checks++;
            if (bus4.fdma_wareq !== 1'b1) begin errors++; $display("FAIL req_hold got=%b want=1", bus4.fdma_wareq); end
        end
        bus4.fdma_wbusy = 1'b1;
        @(negedge ui_clk);
        checks++;
        if (bus4.fdma_wareq !== 1'b0) begin errors++; $display("FAIL req_drop got=%b want=0", bus4.fdma_wareq); end
        repeat (busy_len) begin
            bus4.fdma_wvalid = 1'($urandom);
            for (int c = 0; c < N; c++) bus4.s_wdata[c*DW +: DW] = $urandom;
            bus4.s_waddr[exp*AW +: AW] = AW'($urandom);
            bus4.s_wsize[exp*SW +: SW] = SW'($urandom);
            if (noise && !hold_req) bus4.s_wareq = 4'($urandom);
            exp_data = bus4.s_wdata[exp*DW +: DW];
            exp_vld  = bus4.fdma_wvalid ? 4'(1 << exp) : 4'b0000;
            #1;
            checks++;
            if (bus4.fdma_wdata !== exp_data) begin errors++; $display("FAIL data_mux got=%h want=%h", bus4.fdma_wdata, exp_data); end
            checks++;
            if (bus4.s_wvalid !== exp_vld) begin errors++; $display("FAIL wvalid_route got=%b want=%b", bus4.s_wvalid, exp_vld); end
            checks++;
            if (bus4.fdma_waddr !== exp_addr || bus4.fdma_wsize !== exp_size) begin
                errors++; $display("FAIL hold_stable got=%h/%h want=%h/%h", bus4.fdma_waddr, bus4.fdma_wsize, exp_addr, exp_size);
            end
            @(negedge ui_clk);
        end
        bus4.fdma_wvalid = 1'b0;
        bus4.fdma_wbusy  = 1'b0;
        bus4.s_wareq     = hold_req ? req : 4'b0000;
        @(negedge ui_clk);
        checks++;
        if (bus4.s_wbusy !== 4'b0000) begin errors++; $display("FAIL release_wbusy got=%b want=0000", bus4.s_wbusy); end
        checks++;
        if (arb_active4 !== 1'b0) begin errors++; $display("FAIL release_active got=%b want=0", arb_active4); end
        mptr = (exp + 1) % N;
        granted = exp;
    endtask

    task automatic test_reset();
        bus4.s_waddr = '0; bus4.s_wsize = '0; bus4.s_wareq = '0;
        bus4.fdma_wbusy = 1'b0; bus4.fdma_wvalid = 1'b1;
        bus4.s_wdata = {$urandom, $urandom, $urandom, $urandom};
        bus3.s_waddr = '0; bus3.s_wsize = '0; bus3.s_wareq = '0;
        bus3.fdma_wbusy = 1'b0; bus3.fdma_wvalid = 1'b1;
        bus3.s_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ui_rstn = 1'b0;
        repeat (2) @(negedge ui_clk);
        checks++;
        if (bus4.fdma_wareq !== 1'b0 || bus4.s_wbusy !== 4'b0 || arb_active4 !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b/%b/%b want=0/0000/0", bus4.fdma_wareq, bus4.s_wbusy, arb_active4);
        end
        checks++;
        if (gnt_id4 !== 2'd0 || bus4.fdma_waddr !== '0 || bus4.fdma_wsize !== '0) begin
            errors++; $display("FAIL reset_latch got=%0d/%h/%h want=0/0/0", gnt_id4, bus4.fdma_waddr, bus4.fdma_wsize);
        end
        checks++;
        if (bus4.fdma_wdata !== '0 || bus4.s_wvalid !== 4'b0) begin
            errors++; $display("FAIL reset_comb got=%h/%b want=0/0000", bus4.fdma_wdata, bus4.s_wvalid);
        end
        checks++;
        if (bus3.fdma_wdata !== '0 || bus3.s_wvalid !== 3'b0 || arb_active3 !== 1'b0) begin
            errors++; $display("FAIL reset_dut3 got=%h/%b/%b want=0/000/0", bus3.fdma_wdata, bus3.s_wvalid, arb_active3);
        end
        bus4.fdma_wvalid = 1'b0;
        bus3.fdma_wvalid = 1'b0;
        ui_rstn = 1'b1;
        mptr = 0;
        @(negedge ui_clk);
    endtask

    task automatic test_all_channels();
        int g;
        int order [5] = '{0, 1, 2, 3, 0};
        for (int b = 0; b < 5; b++) begin
            burst(4'b1111, 3, 1'b1, 1'b1, 1'b0, g);
            checks++;
            if (g !== order[b]) begin errors++; $display("FAIL all_order burst=%0d got=%0d want=%0d", b, g, order[b]); end
        end
        bus4.s_wareq = 4'b0000;
    endtask

    task automatic test_single();
        int g;
        bus4.s_waddr[2*AW +: AW] = AW'(32'h1000);
        bus4.s_wsize[2*SW +: SW] = SW'(64);
        burst(4'b0100, 10, 1'b0, 1'b0, 1'b0, g);
        checks++;
        if (g !== 2) begin errors++; $display("FAIL single_gnt got=%0d want=2", g); end
    endtask

    task automatic test_rr_skip();
        int g;
        burst(4'b1000, 2, 1'b0, 1'b1, 1'b0, g);   // leaves the pointer wrapped to 0 after ch3
        burst(4'b0100, 2, 1'b0, 1'b1, 1'b0, g);   // pointer now 3
        burst(4'b0011, 2, 1'b0, 1'b1, 1'b0, g);
        checks++;
        if (g !== 0) begin errors++; $display("FAIL rr_skip_first got=%0d want=0", g); end
        burst(4'b0011, 2, 1'b0, 1'b1, 1'b0, g);
        checks++;
        if (g !== 1) begin errors++; $display("FAIL rr_skip_second got=%0d want=1", g); end
    endtask

    task automatic test_random();
        int g;
        for (int it = 0; it < 24; it++) begin
            burst(4'($urandom_range(1, 15)), $urandom_range(1, 6), 1'b0, 1'b1, 1'b1, g);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge ui_clk);
                checks++;
                if (arb_active4 !== 1'b0 || bus4.fdma_wareq !== 1'b0) begin
                    errors++; $display("FAIL dropped_req got=%b/%b want=0/0", arb_active4, bus4.fdma_wareq);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int g;
        bus4.s_wareq = 4'b0100;
        @(negedge ui_clk);
        bus4.s_wareq = 4'b0000;
        bus4.fdma_wbusy = 1'b1;
        @(negedge ui_clk);
        bus4.fdma_wvalid = 1'b1;
        ui_rstn = 1'b0;
        #1;
        checks++;
        if (bus4.fdma_wareq !== 1'b0 || bus4.s_wbusy !== 4'b0 || arb_active4 !== 1'b0 || gnt_id4 !== 2'd0) begin
            errors++; $display("FAIL midrst_regs got=%b/%b/%b/%0d want=0/0000/0/0", bus4.fdma_wareq, bus4.s_wbusy, arb_active4, gnt_id4);
        end
        checks++;
        if (bus4.fdma_waddr !== '0 || bus4.fdma_wdata !== '0 || bus4.s_wvalid !== 4'b0) begin
            errors++; $display("FAIL midrst_bus got=%h/%h/%b want=0/0/0000", bus4.fdma_waddr, bus4.fdma_wdata, bus4.s_wvalid);
        end
        bus4.fdma_wvalid = 1'b0;
        bus4.fdma_wbusy = 1'b0;
        @(negedge ui_clk);
        ui_rstn = 1'b1;
        mptr = 0;
        @(negedge ui_clk);
        burst(4'b1111, 2, 1'b0, 1'b1, 1'b0, g);
        checks++;
        if (g !== 0) begin errors++; $display("FAIL midrst_restart got=%0d want=0", g); end
    endtask

    task automatic test_width();
        logic [63:0] d [3];
        for (int c = 0; c < 3; c++) begin
            d[c] = {$urandom, $urandom};
            bus3.s_wdata[c*64 +: 64] = d[c];
            bus3.s_waddr[c*AW +: AW] = AW'($urandom);
        end
        bus3.s_wareq = 3'b100;
        @(negedge ui_clk);
        checks++;
        if (gnt_id3 !== 2'd2 || bus3.s_wbusy !== 3'b100 || bus3.fdma_wareq !== 1'b1) begin
            errors++; $display("FAIL w64_grant got=%0d/%b/%b want=2/100/1", gnt_id3, bus3.s_wbusy, bus3.fdma_wareq);
        end
        bus3.s_wareq = 3'b000;
        bus3.fdma_wbusy = 1'b1;
        @(negedge ui_clk);
        bus3.fdma_wvalid = 1'b1;
        #1;
        checks++;
        if (bus3.fdma_wdata !== d[2]) begin errors++; $display("FAIL w64_data got=%h want=%h", bus3.fdma_wdata, d[2]); end
        checks++;
        if (bus3.s_wvalid !== 3'b100) begin errors++; $display("FAIL w64_wvalid got=%b want=100", bus3.s_wvalid); end
        bus3.fdma_wvalid = 1'b0;
        bus3.fdma_wbusy = 1'b0;
        @(negedge ui_clk);
        checks++;
        if (bus3.s_wbusy !== 3'b000) begin errors++; $display("FAIL w64_release got=%b want=000", bus3.s_wbusy); end
        bus3.s_wareq = 3'b111;
        @(negedge ui_clk);
        checks++;
        if (gnt_id3 !== 2'd0) begin errors++; $display("FAIL w64_wrap got=%0d want=0", gnt_id3); end
        bus3.s_wareq = 3'b000;
        bus3.fdma_wbusy = 1'b1;
        @(negedge ui_clk);
        bus3.fdma_wbusy = 1'b0;
        @(negedge ui_clk);
    endtask

    initial begin
        test_reset();
        test_all_channels();
        test_single();
        test_rr_skip();
        test_random();
        test_reset_mid_burst();
        test_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uidbufw_arbiter_rr.md
# uidbufw_arbiter_rr

Parametrised N-channel write arbiter between `uidbuf` write masters and a single FDMA write port. It succeeds the fixed 4-channel, fixed-priority interconnect. It adds round-robin fairness, a registered request handshake (latched address and size), and flattened per-channel buses sized by `CH_NUM`. It sits between the per-stream `uidbuf` write engines and the FDMA/AXI write master in the `ui_clk` domain.

## Interface
- `AXI_DATA_WIDTH`, default 32: FDMA data width.
- `AXI_ADDR_WIDTH`, default 21: FDMA address width.
- `SIZE_WIDTH`, default 16: burst size width.
- `CH_NUM`, default 4: number of write channels. Legal range is 2..16; it need not be a power of two.

Ports:
- `ui_clk`  in  1  Clock.
- `ui_rstn`  in  1  Reset, asynchronous, active-low.
- `s_waddr`  in  CH_NUM*AXI_ADDR_WIDTH  Per-channel start address. Channel k occupies slice [k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH].
- `s_wareq`  in  CH_NUM  Per-channel request level. The source holds it until its `s_wbusy` bit rises.
- `s_wsize`  in  CH_NUM*SIZE_WIDTH  Per-channel burst size.
- `s_wbusy`  out  CH_NUM  Per-channel busy, registered.
- `s_wdata`  in  CH_NUM*AXI_DATA_WIDTH  Per-channel write data.
- `s_wvalid`  out  CH_NUM  Per-channel data strobe, combinational.
- `fdma_waddr`  out  AXI_ADDR_WIDTH  Latched address of the granted channel.
- `fdma_wareq`  out  1  Request to FDMA, registered.
- `fdma_wsize`  out  SIZE_WIDTH  Latched size of the granted channel.
- `fdma_wbusy`  in  1  FDMA busy.
- `fdma_wdata`  out  AXI_DATA_WIDTH  Data of the granted channel, combinational.
- `fdma_wvalid`  in  1  FDMA data strobe.
- `gnt_id`  out  clog2(CH_NUM)  Index of the current or last granted channel.
- `arb_active`  out  1  High in REQ and BUSY.

## Operation
State machine with three states: IDLE, REQ and BUSY.
- **IDLE**
  - If `s_wareq` is nonzero, pick the first requesting channel in round-robin order, starting at `ptr`.
  - Latch `gnt_id`, `fdma_waddr` and `fdma_wsize` from that channel.
  - Set `fdma_wareq` and `s_wbusy[gnt]` to 1, then go to REQ.
- **REQ**
  - Hold `fdma_wareq` = 1.
  - When `fdma_wbusy` = 1, clear `fdma_wareq` and go to BUSY.
- **BUSY**
  - When `fdma_wbusy` = 0, clear `s_wbusy[gnt]`, set `ptr` = gnt+1 (wrapping CH_NUM-1 to 0), and go to IDLE.
- **Data path**
  - `fdma_wdata` is the granted channel's slice whenever `arb_active`=1; otherwise it is 0.
  - `s_wvalid[k]` = `fdma_wvalid` when `arb_active`=1 and k = `gnt_id`; otherwise it is 0.
- **Request sampling**
  - `s_wareq` is sampled only in IDLE.
  - A request dropped before grant is lost without error.
  - Requests arriving during REQ/BUSY wait.
- **Hold stability**: latched address and size stay fixed from grant to IDLE, even if the source changes its inputs.
- **Illegal state encoding**: go to IDLE with all outputs cleared.

## Timing
- **Reset values**: state IDLE, `ptr` 0, `gnt_id` 0, `fdma_waddr` 0, `fdma_wsize` 0, `fdma_wareq` 0, `s_wbusy` 0, `arb_active` 0. Combinational outputs evaluate to 0.
- **Grant latency**: `s_wareq` seen high at edge N produces `fdma_wareq`=1 and `s_wbusy[k]`=1 after edge N.
- **Request drop**: `fdma_wareq` drops at the edge after `fdma_wbusy` is sampled 1.
- **Release**: `fdma_wbusy` sampled 0 in BUSY causes `s_wbusy[k]` to fall at that edge. IDLE lasts at least one cycle, so the minimum gap between grants is 1 cycle.
- **Zero-latency data**: `s_wvalid` and `fdma_wdata` follow `fdma_wvalid` in the same cycle. The FDMA requires data valid with `wvalid`.
- **Round-robin pointer**: the pointer advances only on completion; with a single requester, that channel is re-granted.
- **Simultaneous events**: when all channels request, grant order is `ptr`, `ptr`+1, … with wrap.
- **Reset mid-burst**: asynchronous clear to the reset values; no completion is signalled.

## Structure
- **Shared package**
  - State encoding: IDLE=0, REQ=1, BUSY=2, in a 2-bit state field.
  - `CH_IDX_W` = clog2(CH_NUM), with a minimum of 1.
- **Sub-module `rr_pick`**
  - Combinational round-robin selector.
  - Inputs: request vector and `ptr`.
  - Outputs: grant index and `any` flag.
  - Implemented as a double-width priority scan, width-generic.
- **Top-level logic**: FSM, latch registers and output muxes as indexed part-selects.

## Test plan
- **Single channel** (CH_NUM=4): ch2 requests addr 0x1000, size 64; FDMA busy for 10 cycles. Expect `fdma_wareq`=1 one cycle after the request, `fdma_waddr`=0x1000, `fdma_wsize`=64, `s_wbusy`=4'b0100, and only `s_wvalid[2]` toggling.
- **All channels requesting**: `s_wareq`=4'b1111 held for 4 bursts. Expect grant order 0,1,2,3; on a 5th burst, grant 0 again.
- **Round-robin skip**: `ptr`=3, requests 4'b0011. Expect grant 0, then 1.
- **Input hold**: change `s_waddr` of the granted channel during BUSY. Expect `fdma_waddr` unchanged.
- **Reset mid-burst**: assert `ui_rstn`=0 in BUSY. Expect all registered outputs 0 immediately and `gnt_id`=0; the first request after reset starts from channel 0.
- **Width generality** (CH_NUM=3, AXI_DATA_WIDTH=64): ch2 burst. Expect wrap of `ptr` to 0 and the correct 64-bit `fdma_wdata` slice.
